mem_slot_scheduler: RTL
=======================

Name: mem_slot_scheduler

Overview:
- Sits between the EX stage and the banked data memory (one 64-bit write port A, one read port B).
- Each bundle carries an upper (u) and a lower (l) slot, and each slot may issue one load or store.
- The block maps slot requests onto the two memory ports and serialises conflicting pairs over two cycles, raising interlock for the first.
- It also gives a program loader the write port on otherwise idle cycles, and delays a read tag so writeback knows which slot and lane own mem_doutb.

Parameters:
ADDR_W, 32, width of word addresses
READ_LAT, 3, cycles from mem_addrb issue to valid mem_doutb

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
stall_in  in  1  external freeze; no memory op issued
u_valid  in  1  upper slot memory op present
u_we  in  1  1=store, 0=load
u_addr  in  ADDR_W  upper word address; bit0 selects 32-bit lane
u_wdata  in  32  upper store data
l_valid, l_we, l_addr, l_wdata  in  1/1/ADDR_W/32  same for lower slot
ld_valid  in  1  loader write request
ld_addr  in  ADDR_W  loader address (full 64-bit word)
ld_data  in  64  loader data
ld_ready  out  1  loader beat accepted this cycle
interlock  out  1  upstream must hold the current bundle
mem_addra  out  ADDR_W  write address (registered)
mem_dina  out  64  write data (registered)
mem_wea  out  8  byte write enable (registered)
mem_addrb  out  ADDR_W  read address (registered)
rd_tag_valid  out  1  mem_doutb this cycle belongs to a load
rd_tag_slot  out  1  0=upper, 1=lower
rd_tag_lane  out  1  32-bit lane of mem_doutb to select

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values: state=IDLE; mem_wea=0; mem_addra=0; mem_dina=0; mem_addrb=0; whole tag pipe cleared, so rd_tag_valid=0.
- Store mapping: mem_addra=addr; mem_dina={wdata,wdata}; mem_wea=8'h0F if addr[0]=0, else 8'hF0.
- Load mapping: mem_addrb=addr; a tag {slot, addr[0]} enters the tag pipe.
- Issue timing: an op issued in cycle N drives the mem_* registers at edge N+1.
- Tag timing: the tag appears on rd_tag_* exactly READ_LAT cycles after mem_addrb was registered.
- A cycle with no load pushes an invalid tag into the pipe.
- Write enable: mem_wea is 0 in every cycle that issues no write.
- Conflict: u_valid & l_valid and any of the following:
  - both are stores;
  - both are loads;
  - u is a store, l is a load, and u_addr==l_addr (RAW inside the bundle).
- Non-conflicting pairs issue both slots in the same cycle, store on port A and load on port B.
- A u-load with an l-store to the same address is not a conflict; the load returns old data, which matches program order.
- FSM states:
  - IDLE, conflict and !stall_in: issue u op only; interlock=1 (combinational); next state SECOND.
  - IDLE, no conflict: issue all valid ops; interlock=0; stay in IDLE.
  - SECOND: upstream holds the bundle unchanged; issue l op only; interlock=0; next state IDLE.
- Upstream must not change u_*/l_* while interlock=1.
- stall_in=1: nothing issues (wea=0, invalid tag); FSM state is held; interlock=0; ld_ready=0. The tag pipe still advances.
- Loader arbitration: ld_ready = ld_valid & !stall_in & (port A carries no pipeline store this cycle). This is combinational.
- Loader write: on ld_ready, the next edge sets mem_addra=ld_addr, mem_dina=ld_data, mem_wea=8'hFF.
- Priority: the pipeline always wins port A; the loader never starves while the pipeline issues no stores.
- Reset mid-operation (rstn low in SECOND): the deferred l op is dropped, the FSM returns to IDLE, and in-flight tags are discarded.
- Address width: no arithmetic is performed on addresses, so no wrap-around handling is needed. Addresses pass through at full ADDR_W.

Test Plan:
- Single u load, addr=0x0000_0005 -> mem_addrb=0x5 next cycle, mem_wea=0. After READ_LAT=3 more cycles: rd_tag_valid=1, slot=0, lane=1.
- u store 0xDEADBEEF @0x10 and l load @0x11 -> both in one cycle: mem_wea=8'h0F, mem_dina=0xDEADBEEF_DEADBEEF, mem_addrb=0x11. interlock never asserted.
- Two stores, u@0x20 data 1 and l@0x21 data 2 -> interlock=1 for one cycle. Cycle 1: wea=8'h0F @0x20. Cycle 2: wea=8'hF0 @0x21, dina=0x00000002_00000002.
- u store @0x30 and l load @0x30 -> serialised: write issues first, read issues the following cycle. Tag reports slot=1, lane=0.
- Loader ld_valid held with data 0x0123456789ABCDEF @0x40 while the pipeline stores on alternate cycles -> ld_ready=1 only on non-store cycles; the accepted beat writes wea=8'hFF.
- rstn pulsed low asynchronously while in SECOND and while tags are in flight -> all outputs clear immediately. No rd_tag_valid appears afterward; the FSM is in IDLE on release.

Source files
------------

// File: rtl/mem_slot_if.sv
// Slot request, loader and memory-port bundle between EX, the loader and the
// banked data memory. The scheduler takes the slave side.
interface mem_slot_if #(
    parameter int unsigned ADDR_W = 32
);
    // Pipeline slot requests
    logic              stall_in;
    logic              u_valid;
    logic              u_we;
    logic [ADDR_W-1:0] u_addr;
    logic [31:0]       u_wdata;
    logic              l_valid;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_wdata;
    // Program loader
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [63:0]       ld_data;
    logic              ld_ready;
    // Upstream hold
    logic              interlock;
    // Memory ports and read tag
    logic [ADDR_W-1:0] mem_addra;
    logic [63:0]       mem_dina;
    logic [7:0]        mem_wea;
    logic [ADDR_W-1:0] mem_addrb;
    logic              rd_tag_valid;
    logic              rd_tag_slot;
    logic              rd_tag_lane;

    modport master (
        output stall_in, u_valid, u_we, u_addr, u_wdata,
        output l_valid, l_we, l_addr, l_wdata,
        output ld_valid, ld_addr, ld_data,
        input  ld_ready, interlock,
        input  mem_addra, mem_dina, mem_wea, mem_addrb,
        input  rd_tag_valid, rd_tag_slot, rd_tag_lane
    );

    modport slave (
        input  stall_in, u_valid, u_we, u_addr, u_wdata,
        input  l_valid, l_we, l_addr, l_wdata,
        input  ld_valid, ld_addr, ld_data,
        output ld_ready, interlock,
        output mem_addra, mem_dina, mem_wea, mem_addrb,
        output rd_tag_valid, rd_tag_slot, rd_tag_lane
    );
endinterface

// File: rtl/mem_slot_scheduler.sv
// Maps the upper/lower slot memory ops of a bundle onto write port A and read
// port B, serialising conflicting pairs over two cycles. Idle port-A cycles go
// to the program loader. A delayed tag tells writeback who owns mem_doutb.
module mem_slot_scheduler #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned READ_LAT = 3
) (
    input  logic      clk,
    input  logic      rstn,
    mem_slot_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StSecond} state_t;

    typedef struct packed {
        logic valid;
        logic slot;
        logic lane;
    } tag_t;

    state_t state;
    logic   conflict;
    logic   issue_u;
    logic   issue_l;
    logic   store_u;
    logic   store_l;
    logic   load_u;
    logic   load_l;
    logic   loader_go;
    tag_t   tag_new;
    tag_t   tag_pipe [READ_LAT+1];

    // Pairs that cannot share the two ports in one cycle (u-load/l-store is fine).
    always_comb begin
        conflict = bus.u_valid & bus.l_valid &
                   ((bus.u_we == bus.l_we) |
                    (bus.u_we & ~bus.l_we & (bus.u_addr == bus.l_addr)));
    end

    // Decide which slots issue this cycle, plus interlock, loader grant and new tag.
    always_comb begin
        issue_u       = 1'b0;
        issue_l       = 1'b0;
        bus.interlock = 1'b0;
        if (!bus.stall_in) begin
            unique case (state)
                StIdle: begin
                    if (conflict) begin
                        issue_u       = 1'b1;
                        bus.interlock = 1'b1;
                    end else begin
                        issue_u = bus.u_valid;
                        issue_l = bus.l_valid;
                    end
                end
                StSecond: issue_l = bus.l_valid;
            endcase
        end
        store_u      = issue_u & bus.u_we;
        store_l      = issue_l & bus.l_we;
        load_u       = issue_u & ~bus.u_we;
        load_l       = issue_l & ~bus.l_we;
        loader_go    = bus.ld_valid & ~bus.stall_in & ~(store_u | store_l);
        bus.ld_ready = loader_go;
        tag_new      = '0;
        if (load_u) begin
            tag_new = '{valid: 1'b1, slot: 1'b0, lane: bus.u_addr[0]};
        end else if (load_l) begin
            tag_new = '{valid: 1'b1, slot: 1'b1, lane: bus.l_addr[0]};
        end
    end

    // Slot FSM and registered memory port outputs; stall freezes the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= StIdle;
            bus.mem_wea   <= '0;
            bus.mem_addra <= '0;
            bus.mem_dina  <= '0;
            bus.mem_addrb <= '0;
        end else begin
            if (!bus.stall_in) begin
                unique case (state)
                    StIdle:   if (conflict) state <= StSecond;
                    StSecond: state <= StIdle;
                endcase
            end
            bus.mem_wea <= 8'h00;
            if (store_u) begin
                bus.mem_addra <= bus.u_addr;
                bus.mem_dina  <= {bus.u_wdata, bus.u_wdata};
                bus.mem_wea   <= bus.u_addr[0] ? 8'hF0 : 8'h0F;
            end else if (store_l) begin
                bus.mem_addra <= bus.l_addr;
                bus.mem_dina  <= {bus.l_wdata, bus.l_wdata};
                bus.mem_wea   <= bus.l_addr[0] ? 8'hF0 : 8'h0F;
            end else if (loader_go) begin
                bus.mem_addra <= bus.ld_addr;
                bus.mem_dina  <= bus.ld_data;
                bus.mem_wea   <= 8'hFF;
            end
            if (load_u) begin
                bus.mem_addrb <= bus.u_addr;
            end else if (load_l) begin
                bus.mem_addrb <= bus.l_addr;
            end
        end
    end

    // Tag pipe: stage 0 loads alongside mem_addrb, last stage lines up with mem_doutb.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i <= READ_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= tag_new;
            for (int unsigned i = 1; i <= READ_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign bus.rd_tag_valid = tag_pipe[READ_LAT].valid;
    assign bus.rd_tag_slot  = tag_pipe[READ_LAT].slot;
    assign bus.rd_tag_lane  = tag_pipe[READ_LAT].lane;
endmodule
